bit_serializer: RTL
===================

# bit_serializer

Parallel-to-serial stage that accepts WIDTH-bit words on a valid/ready handshake and shifts them out one bit per enabled clock. It sits directly upstream of the bit-serial sequence detectors in the fsm library and drives their single-bit `in` port. The idle line level is parameterizable, and back-to-back words stream with no gap bit.

## Interface
- `WIDTH`, 8: word width in bits; legal range is ≥ 2.
- `MSB_FIRST`, 1: 1 shifts `s_data[WIDTH-1]` first; 0 shifts `s_data[0]` first.
- `IDLE_BIT`, 1'b1: value driven on `ser_out` when no word is in flight.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `bit_en`  in  1  bit strobe; the serializer advances one bit only in cycles where it is 1.
- `s_data`  in  WIDTH  parallel word, captured on handshake.
- `s_valid`  in  1  upstream word valid.
- `s_ready`  out  1  serializer can accept a word this cycle (combinational).
- `ser_out`  out  1  serial bit to downstream detector (registered).
- `ser_valid`  out  1  `ser_out` carries a data bit (registered).
- `word_done`  out  1  one-cycle pulse: last bit of current word consumed this cycle (combinational).

## Operation
- State machine `ser_state_t`:
  - `SER_IDLE`: no word loaded; `ser_out` = `IDLE_BIT`; `ser_valid` = 0.
  - `SER_SHIFT`: word in shift register; `ser_out` = current bit; `ser_valid` = 1.
- Bit counter `cnt`:
  - Width is `$clog2(WIDTH)`.
  - Counts bits already presented for the current word.
- Handshake fires when `s_valid && s_ready` at a rising edge. `s_data` is sampled only at that edge.
- `s_ready` = !`rst` && (state==SER_IDLE || (state==SER_SHIFT && cnt==WIDTH-1 && bit_en)).
- `word_done` = state==SER_SHIFT && cnt==WIDTH-1 && bit_en.
- Transitions:
  - **SER_IDLE + handshake:**
    - Go to SER_SHIFT, `cnt`←0.
    - `ser_out` ← first bit (`s_data[WIDTH-1]` if `MSB_FIRST`, else `s_data[0]`).
    - Remaining bits go into the shift register.
    - In SER_IDLE a word is accepted irrespective of `bit_en`.
  - **SER_SHIFT, `bit_en`=0:** hold `ser_out`, `cnt`, and the shift register.
  - **SER_SHIFT, `bit_en`=1, `cnt`<WIDTH-1:** present the next bit, `cnt`←`cnt`+1.
  - **SER_SHIFT, `bit_en`=1, `cnt`==WIDTH-1:**
    - With a handshake in the same cycle: load the new word as from SER_IDLE and stay in SER_SHIFT, giving a gapless stream.
    - Without a handshake: go to SER_IDLE, `ser_out`←`IDLE_BIT`, `ser_valid`←0.
- `IDLE_BIT`=1 is the default because a run of 1s keeps the downstream 0110 detectors in their start state, so the idle line produces no false matches.

## Timing
- Reset values (asynchronous, forced while `rst`=1):
  - state SER_IDLE, `cnt`=0, shift register 0.
  - `ser_out`=`IDLE_BIT`, `ser_valid`=0.
  - `s_ready`=0 and `word_done`=0 while `rst` is high.
- Latency: handshake at edge N puts the first bit on `ser_out` after edge N. With `bit_en` held at 1, the last bit appears after edge N+WIDTH-1.
- Throughput: one word per WIDTH enabled cycles. `s_ready` is high in exactly one cycle per word while streaming.
- There is a combinational path from `bit_en` to `s_ready` and `word_done`. Upstream must not make `s_valid` depend on `s_ready`.
- Reset mid-word: the word is discarded, and the output goes to idle level immediately. After `rst` falls, the next accepted word starts from bit 0.
- `s_valid` deasserted mid-word has no effect; the word in flight always completes.

## Structure
- Shared package `fsm_pkg` holds:
  - `ser_state_t` (`SER_IDLE`, `SER_SHIFT`), as a 1-bit enum.
  - The default `IDLE_BIT` localparam.
- Single module with no sub-modules. The shift register direction is selected by a `MSB_FIRST` generate branch.

## Test plan
- **Reset:** assert `rst` for 3 cycles, then release.
  - During `rst`: `ser_out`=1, `ser_valid`=0, `s_ready`=0.
  - In the first cycle after release: `s_ready`=1.
- **Single word:** `bit_en`=1, send 8'h36.
  - `ser_out` = 0,0,1,1,0,1,1,0 on the 8 cycles after the handshake, with `ser_valid`=1 throughout.
  - `word_done` pulses in the 8th bit cycle; the line then returns to 1.
- **Back-to-back:** `s_valid` held with 8'hA5 then 8'h3C.
  - 16 contiguous valid bits: 1010_0101_0011_1100.
  - `s_ready` high only at the initial accept and in the 8th bit cycle.
- **Paced output:** `bit_en` toggles 1,0,1,0 while sending 8'hF0.
  - Each bit is held for 2 cycles; `ser_valid` stays high for 16 cycles.
  - `word_done` fires only in a cycle where `bit_en`=1.
- **LSB-first:** with `MSB_FIRST`=0, send 8'h01.
  - `ser_out` = 1 followed by seven 0s.
- **Reset mid-word:** assert `rst` during bit 4 of 8'h00.
  - `ser_out`=1 and `ser_valid`=0 immediately, without waiting for a clock edge.
  - After release, 8'hFF serializes as eight 1s starting at bit 0.

Source files
------------

// File: rtl/fsm_pkg.sv
// rtl/fsm_pkg.sv - shared types and defaults for the bit-serial fsm library
//
// Purpose: the serializer state enum and the default idle line level.
// Ports: none (package).
package fsm_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  // A run of 1s keeps the downstream 0110 detectors parked in their start
  // state, so an idle line of 1s can never produce a false match.
  localparam logic SER_IDLE_BIT_DEFAULT = 1'b1;

endpackage

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial stage feeding the bit-serial detectors
//
// Purpose: accepts WIDTH-bit words on a valid/ready handshake and shifts them
// out one bit per enabled clock, streaming back-to-back words with no gap.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   bit_en     bit strobe; the stream advances only when high
//   s_data     parallel word, sampled on handshake
//   s_valid    upstream word valid
//   s_ready    word can be accepted this cycle (combinational)
//   ser_out    serial bit (registered)
//   ser_valid  ser_out carries a data bit (registered)
//   word_done  last bit of the current word consumed this cycle (combinational)
module bit_serializer
  import fsm_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = SER_IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-2:0] sh_q, sh_d;      // bits still waiting behind ser_out
  logic             ser_out_q, ser_out_d;

  logic             last_bit;
  logic             load;
  logic             advance;
  logic             load_bit;
  logic             next_bit;
  logic [WIDTH-2:0] load_sh;
  logic [WIDTH-2:0] next_sh;

  // The first bit goes straight to ser_out on load, so the shift register
  // only ever holds the remaining WIDTH-1 bits.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign load_bit = s_data[WIDTH-1];
      assign load_sh  = s_data[WIDTH-2:0];
      assign next_bit = sh_q[WIDTH-2];
      assign next_sh  = sh_q << 1;
    end else begin : g_lsb_first
      assign load_bit = s_data[0];
      assign load_sh  = s_data[WIDTH-1:1];
      assign next_bit = sh_q[0];
      assign next_sh  = sh_q >> 1;
    end
  endgenerate

  assign last_bit = (state_q == SER_SHIFT) && (cnt_q == CNT_LAST) && bit_en;
  assign load     = s_valid && s_ready;
  assign advance  = (state_q == SER_SHIFT) && bit_en && !last_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SER_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      ser_out_q <= IDLE_BIT;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      ser_out_q <= ser_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    ser_out_d = ser_out_q;
    unique case (state_q)
      SER_IDLE: begin
        if (load) begin
          state_d   = SER_SHIFT;
          cnt_d     = '0;
          sh_d      = load_sh;
          ser_out_d = load_bit;
        end
      end
      SER_SHIFT: begin
        // A load on the last bit reuses the idle-load path, giving a gapless stream.
        if (load) begin
          cnt_d     = '0;
          sh_d      = load_sh;
          ser_out_d = load_bit;
        end else if (last_bit) begin
          state_d   = SER_IDLE;
          cnt_d     = '0;
          ser_out_d = IDLE_BIT;
        end else if (advance) begin
          cnt_d     = cnt_q + CNT_W'(1);
          sh_d      = next_sh;
          ser_out_d = next_bit;
        end
      end
      default: begin
        state_d = SER_IDLE;
      end
    endcase
  end

  always_comb begin
    s_ready   = !rst && ((state_q == SER_IDLE) || last_bit);
    word_done = last_bit;
    ser_valid = (state_q == SER_SHIFT);
    ser_out   = ser_out_q;
  end

endmodule
